apb_slave_bank: RTL
===================

// Module: apb_slave_bank
// PURPOSE
//  Parametrised APB slave model for the AHB-APB bridge bench. It backs NUM_SLAVES
//  select lines with a DEPTH-word register file each, replacing the random-data stub.
//  Supports programmable wait states (pready), error response (pslverr) and real
//  write-then-read storage. Sits on the APB side of the bridge and answers the
//  bridge's psel/penable/paddr/pwdata/pwrite.
// PARAMETERS
//  NUM_SLAVES   3   width of psel; one register bank per select line
//  ADDR_WIDTH   32  paddr width
//  DATA_WIDTH   32  pwdata/prdata width
//  DEPTH        16  words per bank, power of 2, >=2; AW = $clog2(DEPTH)
//  WAIT_STATES  0   extra ACCESS cycles before pready (0..15)
// PORTS
//  pclk      in   1           clock, all logic on rising edge
//  preset    in   1           synchronous reset, active-high
//  psel      in   NUM_SLAVES  slave select, one-hot expected
//  penable   in   1           APB access phase
//  pwrite    in   1           1 = write, 0 = read
//  paddr     in   ADDR_WIDTH  byte address
//  pwdata    in   DATA_WIDTH  write data
//  prdata    out  DATA_WIDTH  read data, valid only with pready & !pwrite
//  pready    out  1           transfer completes this cycle
//  pslverr   out  1           error flag, valid only with pready
// BEHAVIOUR
//  Reset (preset=1 at edge): state IDLE, wait counter 0, all bank words 0,
//   latched sel/addr/write/data 0. Outputs pready=0, pslverr=0, prdata=0.
//   Reset mid-transfer abandons the transfer; no write commits.
//  FSM: IDLE, ACCESS.
//   IDLE: at edge with |psel & !penable (setup), latch psel, paddr, pwrite, pwdata;
//    clear counter; go to ACCESS.
//   ACCESS: counter increments each cycle until it equals WAIT_STATES.
//    pready = (state==ACCESS) && (cnt==WAIT_STATES), decoded from registers.
//    At edge with pready=1, go to IDLE.
//    Abort: psel or penable low, or psel differs from latched, before pready.
//     Go to IDLE, no write, no pready.
//  Latency: setup cycle T0, access from T1; pready high in cycle T1+WAIT_STATES.
//   Back-to-back: a new setup is accepted in the cycle after completion.
//  Decode: word index = addr[AW+1:2]; bank = position of the single set psel bit.
//  Error (pslverr=1 with pready):
//   - psel not one-hot at setup;
//   - addr[1:0] != 0 (misaligned);
//   - addr[ADDR_WIDTH-1:AW+2] != 0 (out of range).
//   An errored write does not modify storage; an errored read gives prdata=0.
//  Write: bank[word] <= latched pwdata at the completing edge (pready=1, no error).
//  Read: prdata = bank[word] during the pready cycle; 0 in all other cycles.
//   Read-after-write to the same word returns the new data.
//  pslverr=0 whenever pready=0.
//  Banks are independent; the same index in different banks holds separate data.
// TESTING
//  1 W=0: write 0xDEADBEEF to psel=001, paddr=0x8 -> pready at T1, pslverr=0;
//    read it back -> prdata=0xDEADBEEF.
//  2 W=3: read psel=010, addr 0x0 after reset -> pready low T1..T3, high T4,
//    prdata=0.
//  3 Write 0x11 to bank0 and 0x22 to bank2, both at addr 0x4 -> read back 0x11
//    and 0x22 respectively.
//  4 paddr=0x41 (misaligned), paddr=0x40 (DEPTH=16, out of range), psel=011
//    -> pslverr=1 with pready; later read of word 0 unchanged.
//  5 W=2: drop penable during wait -> no pready, storage unchanged, next setup
//    accepted normally.
//  6 Assert preset during a write's ACCESS -> outputs 0, IDLE next cycle,
//    target word reads 0.

Source files
------------

// File: rtl/apb_slave_bank_if.sv
// APB bus bundle between the bridge (master) and the slave register bank.
// Clock and reset travel as plain ports alongside this bundle.
interface apb_slave_bank_if #(
  parameter int unsigned NUM_SLAVES = 3,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [NUM_SLAVES-1:0] psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_slave_bank.sv
// APB slave model with one DEPTH-word register bank per select line,
// programmable wait states and error response for misaligned/out-of-range/bad-select access.
module apb_slave_bank #(
  parameter int unsigned NUM_SLAVES  = 3,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned WAIT_STATES = 0
) (
  input logic              pclk,
  input logic              preset,
  apb_slave_bank_if.slave  apb
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned BW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  typedef enum logic [0:0] {StIdle, StAccess} state_e;

  state_e                state_q;
  logic [3:0]            cnt_q;
  logic [NUM_SLAVES-1:0] sel_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  write_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] mem_q [NUM_SLAVES][DEPTH];

  logic          ready;
  logic          error;
  logic          commit;
  logic          sel_seen;
  logic          multi_sel;
  logic [BW-1:0] bank;
  logic [AW-1:0] word;

  // Bank is the position of the set select bit; only meaningful when one-hot.
  always_comb begin
    sel_seen  = 1'b0;
    multi_sel = 1'b0;
    bank      = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_q[i]) begin
        if (sel_seen) multi_sel = 1'b1;
        sel_seen = 1'b1;
        bank     = BW'(i);
      end
    end
  end

  assign word   = addr_q[AW+1:2];
  assign ready  = (state_q == StAccess) && (cnt_q == 4'(WAIT_STATES));
  assign error  = !sel_seen || multi_sel || (addr_q[1:0] != 2'b00) ||
                  (addr_q[ADDR_WIDTH-1:AW+2] != '0);
  assign commit = ready && write_q && !error;

  assign apb.pready  = ready;
  assign apb.pslverr = ready && error;
  assign apb.prdata  = (ready && !write_q && !error) ? mem_q[bank][word] : '0;

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      sel_q   <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (|apb.psel && !apb.penable) begin
            sel_q   <= apb.psel;
            addr_q  <= apb.paddr;
            write_q <= apb.pwrite;
            wdata_q <= apb.pwdata;
            cnt_q   <= '0;
            state_q <= StAccess;
          end
        end
        StAccess: begin
          if (ready) begin
            state_q <= StIdle;
          end else if (!(|apb.psel) || !apb.penable || (apb.psel != sel_q)) begin
            // Master walked away before completion: drop the transfer silently.
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      for (int b = 0; b < NUM_SLAVES; b++) begin
        for (int w = 0; w < DEPTH; w++) begin
          mem_q[b][w] <= '0;
        end
      end
    end else if (commit) begin
      mem_q[bank][word] <= wdata_q;
    end
  end
endmodule
